// File: rtl/vedic_pkg.sv
// Shared constants and FSM state type for the Vedic arithmetic datapath.
package vedic_pkg;
  localparam int VEDIC_DW        = 6;
  localparam int VEDIC_VW        = 3;
  localparam int VEDIC_DIV_STEPS = 6;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
endpackage

// File: rtl/vedic_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module vedic_div_step
  import vedic_pkg::*;
(
  input  logic [VEDIC_VW:0]   pr,
  input  logic                dbit,
  input  logic [VEDIC_VW-1:0] divisor,
  output logic [VEDIC_VW:0]   pr_next,
  output logic                q_bit
);
  logic [VEDIC_VW+1:0] shifted;

  // Full-width shift keeps the compare exact; the top bit is only ever set for divisor 0.
  always_comb begin
    shifted = {pr, dbit};
    q_bit   = (shifted >= {2'b00, divisor});
    pr_next = q_bit ? (VEDIC_VW+1)'(shifted - {2'b00, divisor}) : shifted[VEDIC_VW:0];
  end
endmodule

// File: rtl/vedic_div6by3.sv
// 6-bit / 3-bit sequential restoring divider, one quotient bit per clock, start/busy/done handshake.
// VEDIC_DIV_ZERO_DETECT_EN: divisor 0 short-circuits to DONE in 2 cycles and flags div_by_zero.
module vedic_div6by3
  import vedic_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [VEDIC_DW-1:0] dividend,
  input  logic [VEDIC_VW-1:0] divisor,
  output logic [VEDIC_DW-1:0] quotient,
  output logic [VEDIC_VW-1:0] remainder,
  output logic                busy,
  output logic                done,
  output logic                div_by_zero
);
  localparam int DW = VEDIC_DW;
  localparam int VW = VEDIC_VW;
  localparam logic [2:0] LAST_STEP = 3'(VEDIC_DIV_STEPS - 1);

`ifdef VEDIC_DIV_ZERO_DETECT_EN
  localparam bit ZERO_DETECT = 1'b1;
`else
  localparam bit ZERO_DETECT = 1'b0;
`endif

  div_state_t    state;
  logic [DW-1:0] dvd;
  logic [VW-1:0] dvs;
  logic [VW:0]   pr;
  logic [2:0]    count;
  logic [VW:0]   pr_next;
  logic          q_bit;

  vedic_div_step u_step (
    .pr      (pr),
    .dbit    (dvd[DW-1]),
    .divisor (dvs),
    .pr_next (pr_next),
    .q_bit   (q_bit)
  );

  assign remainder = pr[VW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      dvd         <= '0;
      dvs         <= '0;
      pr          <= '0;
      count       <= '0;
      quotient    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            dvd      <= dividend;
            dvs      <= divisor;
            quotient <= '0;
            pr       <= '0;
            count    <= '0;
            busy     <= !(ZERO_DETECT && (divisor == '0));
            state    <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (ZERO_DETECT && (dvs == '0)) begin
            quotient    <= '1;
            pr          <= {1'b0, dvd[VW-1:0]};
            busy        <= 1'b0;
            done        <= 1'b1;
            div_by_zero <= 1'b1;
            state       <= DONE;
          end else begin
            // Dividend is consumed MSB first by shifting the captured copy left.
            dvd      <= dvd << 1;
            pr       <= pr_next;
            quotient <= {quotient[DW-2:0], q_bit};
            if (count == LAST_STEP) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              count <= count + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
